// File: rtl/gravity_ctrl_pkg.sv
// Shared types and default constants for the gravity controller.
// Pure declarations: no latency, no flow control.
package gravity_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_e;

    localparam int TOP_W_DEF       = 25;
    localparam int BASE_TOP_DEF    = 12_000_000;
    localparam int STEP_TOP_DEF    = 1_000_000;
    localparam int SOFT_TOP_DEF    = 1_200_000;
    localparam int MAX_LEVEL_DEF   = 9;
    localparam int LOCK_TICKS_DEF  = 2;

    localparam int LEVEL_W         = 4;
    localparam int LINES_W         = 3;
    localparam int LINES_PER_LEVEL = 10;
    localparam int MAX_LINES       = 4;

    // The board never clears more than four rows; larger codes are clamped.
    function automatic logic [LINES_W-1:0] clamp_lines(input logic [LINES_W-1:0] n);
        return (n > LINES_W'(MAX_LINES)) ? LINES_W'(MAX_LINES) : n;
    endfunction

endpackage

// File: rtl/gravity_ctrl_level_counter.sv
// Accumulates cleared lines into a level; every ten lines advances one level.
// Level updates one cycle after lines_valid; always accepts, no backpressure.
module gravity_ctrl_level_counter
    import gravity_ctrl_pkg::*;
#(
    parameter int MAX_LEVEL = MAX_LEVEL_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               lines_valid_i,
    input  logic [LINES_W-1:0] lines_cleared_i,
    output logic [LEVEL_W-1:0] level_o
);

    logic [3:0]         line_acc_q, line_acc_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [4:0]         sum;

    always_comb begin
        line_acc_d = line_acc_q;
        level_d    = level_q;
        sum        = {1'b0, line_acc_q} + {2'b00, clamp_lines(lines_cleared_i)};
        if (lines_valid_i) begin
            // Accumulator keeps wrapping at max level so the remainder stays meaningful.
            if (sum >= 5'(LINES_PER_LEVEL)) begin
                line_acc_d = 4'(sum - 5'(LINES_PER_LEVEL));
                if (level_q != LEVEL_W'(MAX_LEVEL)) begin
                    level_d = level_q + 1'b1;
                end
            end else begin
                line_acc_d = sum[3:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            line_acc_q <= '0;
            level_q    <= '0;
        end else begin
            line_acc_q <= line_acc_d;
            level_q    <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/gravity_ctrl.sv
// Turns gravity ticks into move-down requests, counts lock delay and sets timer period.
// move_req rises 1 cycle after tick, held until ack; lock_pulse 2 cycles after final blocked ack.
module gravity_ctrl
    import gravity_ctrl_pkg::*;
#(
    parameter int TOP_W      = TOP_W_DEF,
    parameter int BASE_TOP   = BASE_TOP_DEF,
    parameter int STEP_TOP   = STEP_TOP_DEF,
    parameter int SOFT_TOP   = SOFT_TOP_DEF,
    parameter int MAX_LEVEL  = MAX_LEVEL_DEF,
    parameter int LOCK_TICKS = LOCK_TICKS_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               game_active_i,
    input  logic               tick_i,
    input  logic               soft_drop_i,
    output logic               move_req_o,
    input  logic               move_ack_i,
    input  logic               move_ok_i,
    output logic               lock_pulse_o,
    input  logic               lines_valid_i,
    input  logic [LINES_W-1:0] lines_cleared_i,
    output logic [LEVEL_W-1:0] level_o,
    output logic [TOP_W-1:0]   top_o,
    output logic               tick_overrun_o
);

    localparam int CNT_W = (LOCK_TICKS > 1) ? $clog2(LOCK_TICKS) : 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TICKS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic               lock_pulse_q, lock_pulse_d;
    logic               overrun_q, overrun_d;
    logic [TOP_W-1:0]   top_q, top_d;
    logic [LEVEL_W-1:0] level;

    gravity_ctrl_level_counter #(
        .MAX_LEVEL (MAX_LEVEL)
    ) u_level_counter (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .lines_valid_i   (lines_valid_i),
        .lines_cleared_i (lines_cleared_i),
        .level_o         (level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            lock_cnt_q   <= '0;
            lock_pulse_q <= 1'b0;
            overrun_q    <= 1'b0;
            top_q        <= TOP_W'(BASE_TOP);
        end else begin
            state_q      <= state_d;
            lock_cnt_q   <= lock_cnt_d;
            lock_pulse_q <= lock_pulse_d;
            overrun_q    <= overrun_d;
            top_q        <= top_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        if (!game_active_i) begin
            // Abandon any outstanding request; a stray ack later lands in IDLE and is ignored.
            state_d    = ST_IDLE;
            lock_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (tick_i) state_d = ST_REQ;
                ST_REQ: begin
                    if (move_ack_i) begin
                        state_d = ST_IDLE;
                        if (move_ok_i) begin
                            lock_cnt_d = '0;
                        end else if (lock_cnt_q == LOCK_LAST) begin
                            lock_cnt_d = '0;
                            state_d    = ST_LOCK;
                        end else begin
                            lock_cnt_d = lock_cnt_q + 1'b1;
                        end
                    end
                end
                ST_LOCK: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        move_req_o   = (state_q == ST_REQ) && game_active_i;
        lock_pulse_d = (state_q == ST_LOCK) && game_active_i;
        overrun_d    = overrun_q || (tick_i && (state_q != ST_IDLE));
        top_d        = soft_drop_i ? TOP_W'(SOFT_TOP)
                                   : TOP_W'(BASE_TOP) - TOP_W'(level) * TOP_W'(STEP_TOP);
    end

    assign lock_pulse_o   = lock_pulse_q;
    assign tick_overrun_o = overrun_q;
    assign level_o        = level;
    assign top_o          = top_q;

endmodule
